// File: rtl/rle_pixel_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rle_pixel_encoder
// Brief    : Packs a pixel stream into {run length, RGB} records held in a
//            show-ahead FIFO. Optional RLE_STATS_EN adds rec_cnt and len_sum.
// Revision : 1.0 - initial release
// ============================================================================
module rle_pixel_encoder #(
    parameter int CNT_W   = 8,
    parameter int PIXELS  = 16384,
    parameter int FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [7:0]       R,
    input  logic [7:0]       G,
    input  logic [7:0]       B,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_len,
    output logic [7:0]       out_R,
    output logic [7:0]       out_G,
    output logic [7:0]       out_B,
    output logic             frame_done,
    output logic             overflow
`ifdef RLE_STATS_EN
    ,
    output logic [15:0]      rec_cnt,
    output logic [23:0]      len_sum
`endif
);

    localparam int                 c_PIX_W    = $clog2(PIXELS + 1);
    localparam int                 c_REC_W    = CNT_W + 24;
    localparam int                 c_DEPTH    = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0]   c_MAX_LEN  = '1;
    localparam logic [c_PIX_W-1:0] c_LAST_IDX = c_PIX_W'(PIXELS - 1);
    localparam logic [FIFO_AW:0]   c_FULL     = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   c_ONE      = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_run_len;
    logic [23:0]          r_cur;
    logic [c_PIX_W-1:0]   r_pix_cnt;
    logic                 r_frame_done;
    logic                 r_overflow;

    logic [c_REC_W-1:0]   r_mem [c_DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic [c_REC_W-1:0]   r_head;

    logic [23:0]          w_pix;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_new_run;
    logic                 w_extend;
    logic                 w_push;
    logic [c_REC_W-1:0]   w_push_data;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_wr_en;
    logic                 w_drop;
    logic [FIFO_AW-1:0]   w_rd_ptr_nxt;

    assign w_pix        = {R, G, B};
    assign w_last       = (r_pix_cnt == c_LAST_IDX);
    assign w_push_data  = {r_run_len, r_cur};
    assign w_pop        = (r_count != '0) && out_ready;
    assign w_full       = (r_count == c_FULL);
    assign w_wr_en      = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_new_run   = 1'b0;
        w_extend    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (E) begin
                    w_accept    = 1'b1;
                    w_new_run   = 1'b1;
                    w_state_nxt = w_last ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (E) begin
                    w_accept = 1'b1;
                    // A saturated run closes even when the colour still matches
                    if ((w_pix == r_cur) && (r_run_len != c_MAX_LEN)) begin
                        w_extend = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_new_run = 1'b1;
                    end
                    w_state_nxt = w_last ? S_FLUSH : S_RUN;
                end
            end
            S_FLUSH: begin
                w_push      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_len    <= '0;
            r_cur        <= '0;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if (w_new_run) begin
                r_cur     <= w_pix;
                r_run_len <= CNT_W'(1);
            end else if (w_extend) begin
                r_run_len <= r_run_len + 1'b1;
            end
            if (r_state == S_FLUSH) begin
                r_frame_done <= 1'b1;
            end
        end
    end

    // Storage needs no reset: only the head register is ever observable
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head holds its last value when the FIFO drains empty
            if (w_wr_en && ((r_count == '0) || (w_pop && (r_count == c_ONE)))) begin
                r_head <= w_push_data;
            end else if (w_pop && (r_count > c_ONE)) begin
                r_head <= r_mem[w_rd_ptr_nxt];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_len    = r_head[c_REC_W-1:24];
    assign out_R      = r_head[23:16];
    assign out_G      = r_head[15:8];
    assign out_B      = r_head[7:0];
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

`ifdef RLE_STATS_EN
    logic [15:0] r_rec_cnt;
    logic [23:0] r_len_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec_cnt <= '0;
            r_len_sum <= '0;
        end else begin
            if (w_wr_en) begin
                r_rec_cnt <= r_rec_cnt + 1'b1;
            end
            if (w_pop) begin
                r_len_sum <= r_len_sum + 24'(out_len);
            end
        end
    end

    assign rec_cnt = r_rec_cnt;
    assign len_sum = r_len_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rle_pixel_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_pixel_encoder
// Brief    : Directed self-checking bench for rle_pixel_encoder (8, 300 and
//            4 pixel frames on three instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rle_pixel_encoder;

    logic       clk;
    logic       rst;
    logic       e8, e300, e4;
    logic [7:0] pr, pg, pb;
    logic       out_ready;

    logic       v8, v300, v4;
    logic [7:0] len8, len300, len4;
    logic [7:0] r8, g8, b8, r300, g300, b300, r4, g4, b4;
    logic       fd8, fd300, fd4;
    logic       ov8, ov300, ov4;
`ifdef RLE_STATS_EN
    logic [15:0] rc8, rc300, rc4;
    logic [23:0] ls8, ls300, ls4;
`endif

    int errors = 0;
    int checks = 0;

    rle_pixel_encoder #(.CNT_W(8), .PIXELS(8), .FIFO_AW(2)) u_dut8 (
        .clk(clk), .rst(rst), .E(e8), .R(pr), .G(pg), .B(pb),
        .out_ready(out_ready), .out_valid(v8), .out_len(len8),
        .out_R(r8), .out_G(g8), .out_B(b8),
        .frame_done(fd8), .overflow(ov8)
`ifdef RLE_STATS_EN
        , .rec_cnt(rc8), .len_sum(ls8)
`endif
    );

    rle_pixel_encoder #(.CNT_W(8), .PIXELS(300), .FIFO_AW(2)) u_dut300 (
        .clk(clk), .rst(rst), .E(e300), .R(pr), .G(pg), .B(pb),
        .out_ready(out_ready), .out_valid(v300), .out_len(len300),
        .out_R(r300), .out_G(g300), .out_B(b300),
        .frame_done(fd300), .overflow(ov300)
`ifdef RLE_STATS_EN
        , .rec_cnt(rc300), .len_sum(ls300)
`endif
    );

    rle_pixel_encoder #(.CNT_W(8), .PIXELS(4), .FIFO_AW(2)) u_dut4 (
        .clk(clk), .rst(rst), .E(e4), .R(pr), .G(pg), .B(pb),
        .out_ready(out_ready), .out_valid(v4), .out_len(len4),
        .out_R(r4), .out_G(g4), .out_B(b4),
        .frame_done(fd4), .overflow(ov4)
`ifdef RLE_STATS_EN
        , .rec_cnt(rc4), .len_sum(ls4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pix(input logic [7:0] v);
        pr = v;
        pg = v;
        pb = v;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        e8   = 1'b0;
        e300 = 1'b0;
        e4   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        e8        = 1'b0;
        e300      = 1'b0;
        e4        = 1'b0;
        out_ready = 1'b0;
        pix(8'd0);
        #1;
        chk("rst_valid", {31'd0, v8}, 32'd0);
        chk("rst_len", {24'd0, len8}, 32'd0);
        chk("rst_rgb", {8'd0, r8, g8, b8}, 32'd0);
        chk("rst_done", {31'd0, fd8}, 32'd0);
        chk("rst_ovf", {31'd0, ov8}, 32'd0);

        // ---- two runs: 3x10 then 5x20 ----
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e8 = 1'b1;
            pix((i < 3) ? 8'd10 : 8'd20);
            tick();
            if (i == 3) begin
                chk("t1_rec1_valid", {31'd0, v8}, 32'd1);
                chk("t1_rec1_len", {24'd0, len8}, 32'd3);
                chk("t1_rec1_R", {24'd0, r8}, 32'd10);
            end
            if (i == 4) begin
                chk("t1_empty", {31'd0, v8}, 32'd0);
                chk("t1_hold_len", {24'd0, len8}, 32'd3);
            end
        end
        e8 = 1'b0;
        chk("t1_done_early", {31'd0, fd8}, 32'd0);
        tick();
        chk("t1_done", {31'd0, fd8}, 32'd1);
        chk("t1_rec2_valid", {31'd0, v8}, 32'd1);
        chk("t1_rec2_len", {24'd0, len8}, 32'd5);
        chk("t1_rec2_GB", {16'd0, g8, b8}, {16'd0, 8'd20, 8'd20});
        chk("t1_ovf", {31'd0, ov8}, 32'd0);
        tick();
        chk("t1_drained", {31'd0, v8}, 32'd0);

        // ---- 300 identical pixels: saturated run then remainder ----
        do_reset();
        out_ready = 1'b0;
        pix(8'h55);
        e300 = 1'b1;
        repeat (300) tick();
        e300 = 1'b0;
        tick();
        chk("t2_done", {31'd0, fd300}, 32'd1);
        chk("t2_rec1_len", {24'd0, len300}, 32'd255);
        chk("t2_rec1_R", {24'd0, r300}, 32'h55);
        out_ready = 1'b1;
        tick();
        chk("t2_rec2_valid", {31'd0, v300}, 32'd1);
        chk("t2_rec2_len", {24'd0, len300}, 32'd45);
        chk("t2_rec2_B", {24'd0, b300}, 32'h55);
        tick();
        chk("t2_drained", {31'd0, v300}, 32'd0);
        chk("t2_ovf", {31'd0, ov300}, 32'd0);

        // ---- alternating pixels with a stalled consumer: overflow ----
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e8 = 1'b1;
            pix((i % 2 == 0) ? 8'd1 : 8'd2);
            tick();
            if (i == 4) begin
                chk("t3_full_len", {24'd0, len8}, 32'd1);
                chk("t3_full_R", {24'd0, r8}, 32'd1);
                chk("t3_full_noovf", {31'd0, ov8}, 32'd0);
            end
            if (i == 5) chk("t3_ovf_set", {31'd0, ov8}, 32'd1);
        end
        e8 = 1'b0;
        tick();
        chk("t3_done", {31'd0, fd8}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_d1_R", {24'd0, r8}, 32'd2);
        tick();
        chk("t3_d2_R", {24'd0, r8}, 32'd1);
        tick();
        chk("t3_d3_R", {24'd0, r8}, 32'd2);
        chk("t3_d3_valid", {31'd0, v8}, 32'd1);
        tick();
        chk("t3_drained", {31'd0, v8}, 32'd0);

        // ---- push and pop together while full ----
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            e8 = 1'b1;
            pix(8'(i));
            tick();
        end
        chk("t4_full_head", {24'd0, r8}, 32'd1);
        out_ready = 1'b1;
        pix(8'd6);
        tick();
        e8 = 1'b0;
        chk("t4_pp_ovf", {31'd0, ov8}, 32'd0);
        chk("t4_pp_head", {24'd0, r8}, 32'd2);
        tick();
        chk("t4_h3", {24'd0, r8}, 32'd3);
        tick();
        chk("t4_h4", {24'd0, r8}, 32'd4);
        tick();
        chk("t4_tail", {24'd0, r8}, 32'd5);
        chk("t4_tail_valid", {31'd0, v8}, 32'd1);
        tick();
        chk("t4_drained", {31'd0, v8}, 32'd0);
        chk("t4_ovf_end", {31'd0, ov8}, 32'd0);

        // ---- sparse strobes, four distinct pixels ----
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            e4 = 1'b1;
            pix(8'(k));
            tick();
            e4 = 1'b0;
            if (k > 1) begin
                chk("t5_valid", {31'd0, v4}, 32'd1);
                chk("t5_R", {24'd0, r4}, 32'(k - 1));
                chk("t5_len", {24'd0, len4}, 32'd1);
            end
            if (k < 4) begin
                repeat (6) tick();
                chk("t5_gap_empty", {31'd0, v4}, 32'd0);
            end
        end
        tick();
        chk("t5_flush_valid", {31'd0, v4}, 32'd1);
        chk("t5_flush_R", {24'd0, r4}, 32'd4);
        chk("t5_done", {31'd0, fd4}, 32'd1);

        // ---- reset mid-frame, then a clean frame ----
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e8 = 1'b1;
            pix((i < 2) ? 8'd10 : 8'd20);
            tick();
        end
        e8 = 1'b0;
        chk("t6_pre_valid", {31'd0, v8}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, v8}, 32'd0);
        chk("t6_rst_len", {24'd0, len8}, 32'd0);
        chk("t6_rst_R", {24'd0, r8}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e8 = 1'b1;
            pix((i < 4) ? 8'd7 : 8'd8);
            tick();
        end
        e8 = 1'b0;
        chk("t6_done_early", {31'd0, fd8}, 32'd0);
        tick();
        chk("t6_done", {31'd0, fd8}, 32'd1);
        chk("t6_rec1_len", {24'd0, len8}, 32'd4);
        chk("t6_rec1_R", {24'd0, r8}, 32'd7);
        out_ready = 1'b1;
        tick();
        chk("t6_rec2_len", {24'd0, len8}, 32'd4);
        chk("t6_rec2_R", {24'd0, r8}, 32'd8);
        chk("t6_ovf", {31'd0, ov8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rle_pixel_encoder.md
Name: rle_pixel_encoder

Overview:
Downstream neighbour of the RGB plane reader. Consumes its per-pixel strobe E with 8-bit R, G, B and compresses the pixel stream into run-length records (run length + RGB value). Records are buffered in a small show-ahead FIFO and presented on a valid/ready output port for the writer/transmit stage. The block closes the frame automatically after PIXELS pixels.

Parameters:
CNT_W, 8, width of the run-length field; maximum run is 2^CNT_W-1 (255).
PIXELS, 16384, pixels per frame; the last run is flushed after this many accepted pixels.
FIFO_AW, 2, record FIFO address width; depth is 2^FIFO_AW (4).

Ports:
clk  in  1  system clock, all state on the rising edge
rst  in  1  asynchronous reset, active-high
E  in  1  pixel strobe, one pixel per cycle where high (back-to-back allowed)
R  in  8  pixel red, sampled when E=1
G  in  8  pixel green, sampled when E=1
B  in  8  pixel blue, sampled when E=1
out_ready  in  1  consumer accepts the head record
out_valid  out  1  FIFO non-empty
out_len  out  CNT_W  head record run length (1..2^CNT_W-1)
out_R  out  8  head record red
out_G  out  8  head record green
out_B  out  8  head record blue
frame_done  out  1  sticky; set when the final run of the frame has been pushed
overflow  out  1  sticky; set when a record was dropped because the FIFO was full

Behaviour:
- Reset (async): state=IDLE; run_len, cur RGB, pix_cnt and FIFO pointers/count cleared. Outputs out_valid=0, out_len=0, out_R/G/B=0, frame_done=0, overflow=0.
- States: IDLE (no open run), RUN (run open), FLUSH (push final run), DONE.
- IDLE: E=1 -> cur RGB=pixel, run_len=1, pix_cnt+1, go RUN.
- RUN, E=1:
  - Pixel equals cur RGB and run_len<2^CNT_W-1: run_len+1.
  - Pixel differs, or run_len is at max: push {run_len, cur RGB}; start new run with this pixel, run_len=1.
- Frame end: on the edge that accepts pixel number PIXELS, the pixel is processed as above, then state goes to FLUSH. An E=1 in that same edge's merge logic is still processed.
- FLUSH: push the open run, set frame_done, go DONE. This takes exactly one cycle after the last pixel. E is ignored in FLUSH and DONE.
- DONE: idle until rst. out_* continue draining normally.
- Latency: a record pushed on edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass.
- FIFO:
  - Show-ahead: out_* always reflect the head entry; out_len/R/G/B hold their last value when empty.
  - Pop when out_valid && out_ready.
  - Push while full and no pop: record dropped, overflow set, pointers unchanged.
  - Push and pop on the same edge while full: both performed, count unchanged, no overflow.
  - Push and pop on the same edge while count=1: count stays 1 and the new record becomes head.
- Pointers wrap modulo 2^FIFO_AW. The count is FIFO_AW+1 bits wide.
- pix_cnt counts accepted pixels only and must be wide enough to hold PIXELS.
- The sum of out_len over all records in a frame equals PIXELS, unless overflow is set.
- rst mid-frame: open run and FIFO contents are discarded; nothing is pushed.

Optional Feature:
Macro RLE_STATS_EN.
- Defined: adds output rec_cnt [15:0], reset 0, incremented on every accepted push (dropped records excluded), wrapping at 65535->0. Also adds output len_sum [23:0], the sum of out_len over popped records, reset 0.
- Not defined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- PIXELS=8, E every cycle with RGB 10,10,10 x3 then 20,20,20 x5, out_ready=1 -> records (3,10,10,10) then (5,20,20,20); frame_done=1 one cycle after the 8th pixel; overflow=0.
- PIXELS=300, CNT_W=8, 300 identical pixels 0x55 -> records (255,0x55..) and (45,0x55..).
- PIXELS=8, alternating 1,2,1,2..., out_ready=0 -> 4 records stored, out_len=1, head RGB=1; the 5th push sets overflow; after releasing out_ready, exactly 4 records drain.
- FIFO full with a push and a pop on the same edge -> count stays 4, overflow stays 0, new record becomes the tail.
- E spaced 7 cycles apart (reader cadence), PIXELS=4, all pixels distinct -> 4 records of len 1, each with out_valid high 1 cycle after its terminating E or after FLUSH.
- Assert rst after pixel 3 of 8 -> all outputs return to 0 immediately; a new frame of 8 pixels then encodes correctly from the first pixel.
